data_mem_mc: RTL and testbench

//  Parametrised multi-cycle backing data memory behind the L1 data cache; serves cache-miss loads/stores.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_align.sv | 79 +++++++
 rtl/data_mem_mc.sv | 138 +++++++++++++
 tb/tb_data_mem_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the multi-cycle backing data memory.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - FSM state enum (S_IDLE / S_BUSY / S_RESP)
//   - be_assemble(): big-endian lane assembly plus sign/zero extension
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // raw[31:24] is the byte at the lowest address. Sub-word loads take the
    // leading bytes and right-align them; reserved size behaves as a word.
    function automatic logic [31:0] be_assemble(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {{24{sgn & raw[31]}}, raw[31:24]};
            SZ_HALF: res = {{16{sgn & raw[31]}}, raw[31:16]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational address/lane decode for data_mem_mc.
// Optional feature macro: DMEM_ERR_EN (error detection; otherwise err = 0).
// Ports:
//   addr   in   ADDR_W      byte address
//   size   in   2           access size encoding
//   sgn    in   1           sign-extend sub-word loads
//   wdata  in   32          right-aligned store data
//   raw    in   32          four memory bytes at idx[0..3], idx[0] in [31:24]
//   idx    out  4 x IDX_W   byte indices addr+0..3, wrapping modulo depth
//   be     out  4           per-lane write enables (all 0 on error)
//   wbyte  out  4 x 8       store byte per lane, lane 0 = lowest address
//   err    out  1           access error
//   ldata  out  32          extended load data
module dmem_align
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 10
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic [1:0]                size,
    input  logic                      sgn,
    input  logic [31:0]               wdata,
    input  logic [31:0]               raw,
    output logic [3:0][IDX_W-1:0]     idx,
    output logic [3:0]                be,
    output logic [3:0][7:0]           wbyte,
    output logic                      err,
    output logic [31:0]               ldata
);

    // IDX_W-bit addition wraps modulo the memory depth for free.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            idx[i] = addr[IDX_W-1:0] + IDX_W'(i);
        end
    end

`ifdef DMEM_ERR_EN
    always_comb begin
        err = 1'b0;
        if (size == SZ_RSVD)                          err = 1'b1;
        if (size == SZ_HALF && addr[0])               err = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00)    err = 1'b1;
        if ((addr >> IDX_W) != '0)                    err = 1'b1;
    end
`else
    // Upper address bits are deliberately dropped when errors are disabled.
    logic unused_hi;
    assign unused_hi = |(addr >> IDX_W);
    assign err       = 1'b0;
`endif

    always_comb begin
        wbyte = '0;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001;
                wbyte[0] = wdata[7:0];
            end
            SZ_HALF: begin
                be       = 4'b0011;
                wbyte[0] = wdata[15:8];
                wbyte[1] = wdata[7:0];
            end
            default: begin
                be       = 4'b1111;
                wbyte[0] = wdata[31:24];
                wbyte[1] = wdata[23:16];
                wbyte[2] = wdata[15:8];
                wbyte[3] = wdata[7:0];
            end
        endcase
        if (err) be = '0;
    end

    assign ldata = be_assemble(raw, size, sgn);

endmodule

// File: rtl/data_mem_mc.sv
// data_mem_mc: multi-cycle big-endian backing data memory behind the L1 D$.
// One transaction in flight; fixed LATENCY from acceptance to resp_valid.
// Optional feature macro: DMEM_ERR_EN (misalign / reserved size / out-of-range
// errors; when undefined resp_err is 0 and addresses wrap).
// Ports:
//   clk, rstn (async active-low)
//   req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_err
module data_mem_mc
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 10,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_sgn;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [7:0]         mem [DEPTH_BYTES];

    logic [3:0][IDX_W-1:0] idx;
    logic [3:0]            be;
    logic [3:0][7:0]       wbyte;
    logic                  a_err;
    logic [31:0]           ldata;
    logic [31:0]           raw;
    logic                  accept;
    logic                  fire;

    assign accept = req_valid && (state == S_IDLE);
    assign fire   = (state == S_BUSY) && (cnt == '0);
    assign raw    = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};

    dmem_align #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_align (
        .addr  (r_addr),
        .size  (r_size),
        .sgn   (r_sgn),
        .wdata (r_wdata),
        .raw   (raw),
        .idx   (idx),
        .be    (be),
        .wbyte (wbyte),
        .err   (a_err),
        .ldata (ldata)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid)  state_nx = S_BUSY;
            S_BUSY:  if (cnt == '0)  state_nx = S_RESP;
            S_RESP:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    // Request capture and latency counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sgn   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            r_we    <= req_we;
            r_size  <= req_size;
            r_sgn   <= req_signed;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if (state == S_BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response registers: captured on the access edge, held through RESP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (fire) begin
            resp_rdata <= (r_we || a_err) ? '0 : ldata;
            resp_err   <= a_err;
        end
    end

    // Byte array; reset clears every byte so an aborted store leaves nothing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem <= '{default: '0};
        end else if (fire && r_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx[i]] <= wbyte[i];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mc.sv
module tb_data_mem_mc;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] mm [DEPTH];

    always #5 clk = ~clk;

    data_mem_mc #(
        .DEPTH_BYTES (DEPTH),
        .LATENCY     (LAT),
        .ADDR_W      (32)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    endtask

    // Reference model: computes the response and applies a store to mm.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] exp_d, output logic exp_e);
        int unsigned n;
        int unsigned base;
        longint unsigned v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = ad % DEPTH;
`ifdef DMEM_ERR_EN
        exp_e = (sz == 2'd3) || ((ad % n) != 0) || (ad >= DEPTH);
`else
        exp_e = 1'b0;
`endif
        exp_d = 32'h0;
        if (!exp_e) begin
            if (we) begin
                for (int j = 0; j < n; j++)
                    mm[(base + j) % DEPTH] = 8'((wd >> (8 * (n - 1 - j))) & 32'hFF);
            end else begin
                v = 0;
                for (int j = 0; j < n; j++)
                    v = (v << 8) | longint'(mm[(base + j) % DEPTH]);
                if (sg && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
                    v = v | ~((64'd1 << (8 * n)) - 1);
                exp_d = 32'(v);
            end
        end
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input int unsigned hold, input string tag,
                       output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int unsigned k;
        model(we, sz, sg, ad, wd, exp_d, exp_e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // fields after acceptance must be ignored
        req_valid = 1'b0; req_we = $urandom; req_size = $urandom;
        req_signed = $urandom; req_addr = $urandom; req_wdata = $urandom;
        k = 0;
        while (!resp_valid && k < LAT + 20) begin
            if (req_ready) chk({tag, "/busy_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        chk({tag, "/latency"}, k, LAT);
        got_d = resp_rdata;
        got_e = resp_err;
        chk({tag, "/rdata"}, got_d, exp_d);
        chk({tag, "/err"}, 32'(got_e), 32'(exp_e));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, resp_rdata, got_d);
            chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "/done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "/done_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] ad;

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset/req_ready", 32'(req_ready), 32'd1);
        chk("reset/resp_valid", 32'(resp_valid), 32'd0);
        chk("reset/rdata", resp_rdata, 32'd0);
        chk("reset/err", 32'(resp_err), 32'd0);
        rstn = 1'b1;

        // word store / load
        txn(1'b1, 2'd2, 1'b0, 32'h010, 32'h1122_3344, 0, "st_w10", d, e);
        chk("st_w10/zero", d, 32'h0);
        txn(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, "ld_w10", d, e);
        chk("ld_w10/const", d, 32'h1122_3344);
        txn(1'b0, 2'd0, 1'b0, 32'h010, 32'h0, 0, "ld_b10", d, e);
        chk("ld_b10/const", d, 32'h11);

        // sub-word
        txn(1'b1, 2'd0, 1'b0, 32'h013, 32'hABCD_EF80, 0, "st_b13", d, e);
        txn(1'b0, 2'd0, 1'b1, 32'h013, 32'h0, 0, "ld_bs13", d, e);
        chk("ld_bs13/const", d, 32'hFFFF_FF80);
        txn(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 0, "ld_bu13", d, e);
        chk("ld_bu13/const", d, 32'h0000_0080);
        txn(1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 0, "ld_hs12", d, e);
        chk("ld_hs12/const", d, 32'h0000_3380);

        // backpressure
        txn(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 5, "bp", d, e);
        chk("bp/const", d, 32'h1122_3380);

        // error / out-of-range behaviour
        txn(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, 0, "ld_w02", d, e);
        txn(1'b1, 2'd2, 1'b0, 32'h400, 32'h5566_7788, 0, "st_w400", d, e);
        txn(1'b0, 2'd0, 1'b0, 32'h000, 32'h0, 0, "ld_b00", d, e);
`ifdef DMEM_ERR_EN
        chk("ld_b00/const", d, 32'h00);
`else
        chk("ld_b00/const", d, 32'h55);
        // wrap
        txn(1'b1, 2'd2, 1'b0, 32'h3FE, 32'hA1B2_C3D4, 0, "st_wrap", d, e);
        txn(1'b0, 2'd0, 1'b0, 32'h3FE, 32'h0, 0, "wrap3FE", d, e);
        chk("wrap3FE/const", d, 32'hA1);
        txn(1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0, 0, "wrap3FF", d, e);
        chk("wrap3FF/const", d, 32'hB2);
        txn(1'b0, 2'd0, 1'b0, 32'h000, 32'h0, 0, "wrap000", d, e);
        chk("wrap000/const", d, 32'hC3);
        txn(1'b0, 2'd0, 1'b0, 32'h001, 32'h0, 0, "wrap001", d, e);
        chk("wrap001/const", d, 32'hD4);
`endif

        // randomized traffic; addresses kept in a small window to force reuse
        for (int t = 0; t < 60; t++) begin
            ad = ($urandom_range(0, 15) + 32'h3F8) % DEPTH;
            if ($urandom_range(0, 7) == 0) ad = ad | 32'h1000;
            txn(1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom,
                $urandom_range(0, 3), "rand", d, e);
        end

        // reset mid-operation
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h020; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid/rdata", resp_rdata, 32'd0);
        chk("rst_mid/err", 32'(resp_err), 32'd0);
        chk("rst_mid/req_ready", 32'(req_ready), 32'd1);
        clear_model();
        @(negedge clk);
        rstn = 1'b1;
        txn(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 0, "rst_ld20", d, e);
        chk("rst_ld20/const", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
